// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared types and width defaults for the CPU memory bus.
// Provides arbiter FSM states, transaction owner ids and bus widths.
package cpu_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ADDR,
        WAIT_DATA
    } arb_state_t;

    typedef enum logic {
        OWN_INST,
        OWN_DATA
    } owner_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: fetch, load/store and shared memory port signals.
// slave = arbiter view, master = environment (requesters + memory) view.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = cpu_bus_pkg::ADDR_W,
    parameter int DATA_W = cpu_bus_pkg::DATA_W
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic                data_req;
    logic                data_wr;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_req;
    logic                mem_wr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational grant choice between fetch and data.
// In: inst_req, data_req, streak_full. Out: grant_valid, grant_owner.
module sram_arb_pick
    import cpu_bus_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  logic   streak_full,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = inst_req | data_req;
        // data wins contention until inst has waited out a full streak
        if (data_req && !(inst_req && streak_full)) begin
            grant_owner = OWN_DATA;
        end else begin
            grant_owner = OWN_INST;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like port between fetch and data.
// Ports: clk, rst (async, active-high), bus (sram_bus_arbiter_if.slave).
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    sram_bus_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]       streak_q, streak_d;

    logic   grant_valid;
    owner_t grant_owner;
    logic   addr_hit;
    logic   data_hit;

    sram_arb_pick u_pick (
        .inst_req    (bus.inst_req),
        .data_req    (bus.data_req),
        .streak_full (streak_q == STREAK_MAX),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = WAIT_ADDR;
                    owner_d = grant_owner;
                    if (grant_owner == OWN_DATA) begin
                        wr_d    = bus.data_wr;
                        wstrb_d = bus.data_wstrb;
                        addr_d  = bus.data_addr;
                        wdata_d = bus.data_wdata;
                        // only a data grant that made inst wait extends the streak
                        streak_d = bus.inst_req ? streak_q + 1'b1 : '0;
                    end else begin
                        wr_d     = 1'b0;
                        wstrb_d  = '0;
                        addr_d   = bus.inst_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            WAIT_ADDR: begin
                if (bus.mem_addr_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_INST;
            wr_q     <= 1'b0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
        end
    end

    // handshakes are only honoured in their own state
    assign addr_hit = (state_q == WAIT_ADDR) && bus.mem_addr_ok;
    assign data_hit = (state_q == WAIT_DATA) && bus.mem_data_ok;

    assign bus.mem_req   = (state_q == WAIT_ADDR);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.inst_addr_ok = addr_hit && (owner_q == OWN_INST);
    assign bus.data_addr_ok = addr_hit && (owner_q == OWN_DATA);
    assign bus.inst_data_ok = data_hit && (owner_q == OWN_INST);
    assign bus.data_data_ok = data_hit && (owner_q == OWN_DATA);
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

endmodule
